// File: rtl/unary_tape_writer.sv
// unary_tape_writer
//   Builds the unary tape image 0, A ones, 0, B ones, 0, zero padding,
//   one cell per active cycle under a moving write head. Cell 1 is the MSB.
//   The resulting tape connects directly to the tape input of the unary adder.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   step         (UNARY_TAPE_STEP_EN only) advance enable for write states
//   a, b         operands; lengths of the two runs of ones
//   tape         tape image [1:TAPE_LEN]
//   head         current write-head cell index
//   busy         high from the accepted start until done
//   done         one-cycle completion pulse
//   err          operands do not fit; held until the next accepted start
//
// Optional feature macro: UNARY_TAPE_STEP_EN
module unary_tape_writer #(
  parameter int TAPE_LEN = 10,
  parameter int OP_W     = 4,
  parameter int HEAD_W   = $clog2(TAPE_LEN+2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef UNARY_TAPE_STEP_EN
  input  logic              step,
`endif
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [1:TAPE_LEN] tape,
  output logic [HEAD_W-1:0] head,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEAD, WR_A, SEP, WR_B, TAIL, DONE} state_t;

  state_t              state_q, state_n;
  logic [1:TAPE_LEN]   tape_n;
  logic [HEAD_W-1:0]   head_n;
  logic [OP_W-1:0]     cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic                busy_n, done_n, err_n;
  logic                wr_en, wr_bit, adv, fit;
  logic [OP_W+1:0]     len;

  // Two extra bits hold a+b+3 without wrap for any operand pair.
  assign len = (OP_W+2)'(a) + (OP_W+2)'(b) + (OP_W+2)'(3);
  assign fit = int'(len) <= TAPE_LEN;

`ifdef UNARY_TAPE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_n = state_q;
    tape_n  = tape;
    head_n  = head;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = err;
    wr_en   = 1'b0;
    wr_bit  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (fit) begin
          cnt_a_n = a;
          cnt_b_n = b;
          tape_n  = '0;
          head_n  = HEAD_W'(1);
          err_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = LEAD;
        end else begin
          // Rejected request: tape and head keep the previous result.
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
      LEAD: if (adv) begin
        wr_en   = 1'b1;
        state_n = (cnt_a == '0) ? SEP : WR_A;
      end
      WR_A: if (adv) begin
        wr_en   = 1'b1;
        wr_bit  = 1'b1;
        cnt_a_n = cnt_a - OP_W'(1);
        if (cnt_a == OP_W'(1)) state_n = SEP;
      end
      SEP: if (adv) begin
        wr_en   = 1'b1;
        state_n = (cnt_b == '0) ? TAIL : WR_B;
      end
      WR_B: if (adv) begin
        wr_en   = 1'b1;
        wr_bit  = 1'b1;
        cnt_b_n = cnt_b - OP_W'(1);
        if (cnt_b == OP_W'(1)) state_n = TAIL;
      end
      TAIL: if (adv) begin
        wr_en   = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (wr_en) begin
      tape_n[head] = wr_bit;
      head_n       = head + HEAD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tape    <= '0;
      head    <= HEAD_W'(1);
      cnt_a   <= '0;
      cnt_b   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      tape    <= tape_n;
      head    <= head_n;
      cnt_a   <= cnt_a_n;
      cnt_b   <= cnt_b_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_unary_tape_writer.sv
// Bench for unary_tape_writer: scoreboard of expected tape/head/err/latency,
// pushed when a start is driven and popped when done is observed.
module tb_unary_tape_writer;
  localparam int TL = 10;
  localparam int OW = 4;
  localparam int HW = $clog2(TL+2);

  logic          clk, rst_n, start;
  logic [OW-1:0] a, b;
  logic [1:TL]   tape;
  logic [HW-1:0] head;
  logic          busy, done, err;
`ifdef UNARY_TAPE_STEP_EN
  logic          step;
`endif

  unary_tape_writer #(.TAPE_LEN(TL), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef UNARY_TAPE_STEP_EN
    .step(step),
`endif
    .a(a), .b(b), .tape(tape), .head(head),
    .busy(busy), .done(done), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:TL]   tape;
    logic [HW-1:0] head;
    logic          err;
    int            lat;
    int            bcnt;
  } exp_t;

  exp_t        sb[$];
  int          tests, fails;
  logic [1:TL] last_tape;
  logic [HW-1:0] last_head;

  function automatic logic [1:TL] model_tape(int ia, int ib);
    logic [1:TL] t;
    for (int i = 1; i <= TL; i++)
      t[i] = (i >= 2 && i <= ia + 1) || (i >= ia + 3 && i <= ia + 2 + ib);
    return t;
  endfunction

  task automatic push_exp(int ia, int ib);
    exp_t e;
    int   l;
    l = ia + ib + 3;
    if (l <= TL) begin
      e.tape = model_tape(ia, ib);
      e.head = HW'(l + 1);
      e.err  = 1'b0;
      e.lat  = l + 2;
      e.bcnt = l + 1;
    end else begin
      e.tape = last_tape;
      e.head = last_head;
      e.err  = 1'b1;
      e.lat  = 2;
      e.bcnt = 0;
    end
    last_tape = e.tape;
    last_head = e.head;
    sb.push_back(e);
  endtask

  // Runs one operation; inject=1 fires a second start while busy.
  task automatic run_op(string nm, int ia, int ib, bit inject);
    exp_t e;
    int   n, bc;
    bit   got;
    push_exp(ia, ib);
    @(negedge clk);
    a = OW'(ia); b = OW'(ib); start = 1'b1;
    n = 0; bc = 0; got = 1'b0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) got = 1'b1;
      if (n == 1) begin
        start = 1'b0;
        a = OW'($urandom); b = OW'($urandom);
      end
      if (inject && n == 3) start = 1'b1;
      if (inject && n == 4) start = 1'b0;
    end
    e = sb.pop_front();
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s timeout: no done after %0d cycles, required within %0d", nm, n, e.lat);
      return;
    end
    tests++; if (n !== e.lat) begin fails++;
      $display("FAIL %s latency: got %0d required %0d", nm, n, e.lat); end
    tests++; if (tape !== e.tape) begin fails++;
      $display("FAIL %s tape: got %b required %b", nm, tape, e.tape); end
    tests++; if (head !== e.head) begin fails++;
      $display("FAIL %s head: got %0d required %0d", nm, head, e.head); end
    tests++; if (err !== e.err) begin fails++;
      $display("FAIL %s err: got %b required %b", nm, err, e.err); end
    tests++; if (bc !== e.bcnt) begin fails++;
      $display("FAIL %s busy cycles: got %0d required %0d", nm, bc, e.bcnt); end
    // done is a single-cycle pulse and nothing was queued behind it
    bc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    tests++; if (bc !== 0) begin fails++;
      $display("FAIL %s idle after done: got %0d active cycles required 0", nm, bc); end
    tests++; if (tape !== e.tape || err !== e.err) begin fails++;
      $display("FAIL %s hold: got tape %b err %b required %b %b", nm, tape, err, e.tape, e.err); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef UNARY_TAPE_STEP_EN
    step = 1'b1;
`endif
    repeat (2) @(negedge clk);
    tests++; if (tape !== '0) begin fails++; $display("FAIL reset tape: got %b required 0", tape); end
    tests++; if (head !== HW'(1)) begin fails++; $display("FAIL reset head: got %0d required 1", head); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b required 0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset err: got %b required 0", err); end
    rst_n = 1'b1;
    last_tape = '0; last_head = HW'(1);
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op("a4b3", 4, 3, 1'b0);
    run_op("a0b2", 0, 2, 1'b0);
    run_op("a0b0", 0, 0, 1'b0);
    run_op("a7b0_full", 7, 0, 1'b0);
    run_op("a3b4_full", 3, 4, 1'b0);
  endtask

  task automatic test_err();
    run_op("a5b3_err", 5, 3, 1'b0);
    run_op("a15b15_err", 15, 15, 1'b0);
    run_op("a1b1_after_err", 1, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("a4b3_busy_start", 4, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push_exp(4, 3);
    @(negedge clk);
    a = 4'd4; b = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);   // two cells written, third write would be the next edge
    rst_n = 1'b0;
    #1;
    e = sb.pop_front();   // abandoned, never completes
    tests++; if (tape !== '0 || head !== HW'(1) || busy !== 1'b0) begin fails++;
      $display("FAIL reset_mid: got tape %b head %0d busy %b required 0 1 0", tape, head, busy); end
    last_tape = '0; last_head = HW'(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("a2b2_after_reset", 2, 2, 1'b0);
  endtask

`ifdef UNARY_TAPE_STEP_EN
  task automatic test_step();
    int   n, ns;
    logic [HW-1:0] ph;
    logic ps;
    bit   got;
    @(negedge clk);
    step = 1'b0; a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; ns = 0; got = 1'b0;
    ph = head; ps = 1'b0;
    while (!got && n < 100) begin
      step = (n % 3 == 2);
      ps = step;
      ph = head;
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (busy) begin
        tests++;
        if (head !== (ps ? ph + HW'(1) : ph)) begin fails++;
          $display("FAIL step head: got %0d required %0d", head, ps ? ph + HW'(1) : ph); end
        if (ps) ns++;
      end
    end
    step = 1'b1;
    tests++; if (!got) begin fails++; $display("FAIL step timeout: no done"); end
    tests++; if (tape !== 10'b0101000000) begin fails++;
      $display("FAIL step tape: got %b required 0101000000", tape); end
    tests++; if (ns !== 5) begin fails++;
      $display("FAIL step count: got %0d required 5", ns); end
    last_tape = tape; last_head = HW'(6);
    @(negedge clk);
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UNARY_TAPE_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unary_tape_writer.md
Name: unary_tape_writer

Overview:
- Writer side of the unary tape format consumed by the tape-machine unary adder.
- Takes two binary operands and builds a tape image of the form 0, A ones, 0, B ones, 0, then zero padding.
- Moves a write head one cell per step, so tape construction is observable cell by cell, as on the adder side.
- Output tape feeds the adder's tape input directly. Cell 1 is the MSB (index range 1..TAPE_LEN).

Parameters:
- TAPE_LEN, 10, number of tape cells, indexed 1..TAPE_LEN.
- OP_W, 4, width of each binary operand.
- HEAD_W, $clog2(TAPE_LEN+2), width of the head position output.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  OP_W  first operand; number of ones in the first run.
- b  input  OP_W  second operand; number of ones in the second run.
- tape  output  [1:TAPE_LEN]  tape image under construction / result.
- head  output  HEAD_W  current write-head cell index.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  operands do not fit on the tape; held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tape=0, head=1, busy=0, done=0, err=0, state=IDLE.
  - Counters cleared. Reset mid-operation abandons the write immediately.
- Fit check:
  - Required length is L = a+b+3, computed at OP_W+2 bits with no wrap.
  - Fit when L <= TAPE_LEN.
- IDLE:
  - start=1 with fit: latch a into cnt_a and b into cnt_b; clear tape to all 0; set head=1, err=0, busy=1; go to LEAD.
  - start=1 without fit: tape unchanged; err=1; go to DONE.
- LEAD: tape[head]=0, head+1. Next state is SEP if cnt_a==0, else WR_A.
- WR_A: tape[head]=1, head+1, cnt_a-1. Go to SEP when cnt_a was 1.
- SEP: tape[head]=0, head+1. Next state is TAIL if cnt_b==0, else WR_B.
- WR_B: tape[head]=1, head+1, cnt_b-1. Go to TAIL when cnt_b was 1.
- TAIL: tape[head]=0, head+1. Go to DONE.
- DONE: done=1 for exactly this cycle, busy=0; go to IDLE.
- Outputs:
  - tape and err are stable from DONE until the next accepted start.
  - head ends at L+1.
- Timing:
  - Exactly one cell is written per active cycle; L write cycles in total.
  - With the start sample at edge 0, cells are written at edges 1..L, and done is high during the cycle after edge L+1.
  - Error path: done is high during the cycle after edge 1.
- Cells beyond L remain 0, because the tape is cleared on accept.
- start while busy or in DONE: ignored, not queued.
- Operand inputs are not sampled after the start cycle; changing them mid-operation has no effect.
- Case L == TAPE_LEN exactly: valid; the final 0 lands in cell TAPE_LEN.

Optional Feature:
- Macro: UNARY_TAPE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - LEAD, WR_A, SEP, WR_B and TAIL advance (write, move head, change state) only in cycles where step=1; otherwise all state holds.
  - IDLE acceptance and DONE are unaffected by step.
- When not defined: no step port; the machine advances every cycle as above.

Test Plan:
- a=4, b=3, TAPE_LEN=10: pulse start → after 10 write cycles, tape=0111101110, head=11, done pulse in the following cycle, busy high for 11 cycles, err=0.
- a=0, b=2: start → tape=0011000000 (0, sep 0, 11, 0), done after 5 writes, head=6; the WR_A state is never entered.
- a=5, b=3 (L=11 > 10): start → err=1, tape keeps its previous value, done after 1 cycle; a following fitting start (a=1, b=1) clears err and gives tape=0101000000.
- Second start pulse during busy with a=4, b=3: ignored; result still 0111101110 with a single done pulse.
- rst_n low at the 3rd write cycle of a=4, b=3: immediate tape=0, head=1, busy=0; after release, start with a=2, b=2 → 0110110000 correct.
- UNARY_TAPE_STEP_EN defined: a=1, b=1 with step pulsed every 3rd cycle → head advances only on step cycles; final tape=0101000000, done after the 5th step.
